// File: rtl/uart_parity_engine.sv
// Serial parity generator/checker shared by the UART TX and RX datapaths.
// Accumulates parity over LSB-first data bits and checks a received parity bit.
module uart_parity_engine #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [3:0]       data_len,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             par_valid,
  input  logic             par_in,
  input  logic             clr_err,
  output logic             parity_out,
  output logic             parity_ready,
  output logic             busy,
  output logic [IDX_W-1:0] bit_idx,
  output logic             parity_err,
  output logic             err_sticky
);

  typedef enum logic [1:0] {IDLE, ACCUM, READY} state_t;

  state_t           state;
  logic [2:0]       mode_q;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] len_clamped;
  logic [IDX_W-1:0] idx_next;
  logic             acc;
  logic             acc_next;
  logic             par_calc;
  logic             checking;

  // Frame length is forced into the legal 5..DATA_W window when sampled.
  always_comb begin
    len_clamped = IDX_W'(data_len);
    if (int'(data_len) < 5)
      len_clamped = IDX_W'(5);
    else if (int'(data_len) > DATA_W)
      len_clamped = IDX_W'(DATA_W);
  end

  // Parity value as it will stand once the current bit is folded in.
  always_comb begin
    acc_next = acc ^ bit_in;
    idx_next = bit_idx + IDX_W'(1);
    checking = (mode_q >= 3'd1) && (mode_q <= 3'd4);
    case (mode_q)
      3'b001:  par_calc = acc_next;
      3'b010:  par_calc = ~acc_next;
      3'b011:  par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= 3'b000;
      len_q        <= IDX_W'(5);
      acc          <= 1'b0;
      bit_idx      <= '0;
      parity_out   <= 1'b0;
      parity_ready <= 1'b0;
      busy         <= 1'b0;
      parity_err   <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      // A later set in this block overrides the clear.
      if (clr_err)
        err_sticky <= 1'b0;
      if (start) begin
        state        <= ACCUM;
        mode_q       <= mode;
        len_q        <= len_clamped;
        acc          <= 1'b0;
        bit_idx      <= '0;
        parity_out   <= 1'b0;
        parity_ready <= 1'b0;
        busy         <= 1'b1;
      end else begin
        case (state)
          ACCUM: begin
            if (bit_valid) begin
              acc     <= acc_next;
              bit_idx <= idx_next;
              if (idx_next == len_q) begin
                state        <= READY;
                busy         <= 1'b0;
                parity_ready <= 1'b1;
                parity_out   <= par_calc;
              end
            end
          end
          READY: begin
            if (par_valid) begin
              state        <= IDLE;
              parity_ready <= 1'b0;
              if (checking && (par_in != parity_out)) begin
                parity_err <= 1'b1;
                err_sticky <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
